sipo_deser: RTL and testbench

- Serial-in/parallel-out receive end of the left-shift/load serializer: reassembles SIZE-bit words from an MSB-first serial bit stream.
- The transmitter emits Q[SIZE-1] first, shifting left once per enabled clock; this block shifts left and appends each received bit at the LSB.
- Completed words are presented on a held valid/ack output handshake, with overrun detection.
- Sits between the serializer output and the consumer register file or datapath.

---
 rtl/sipo_deser_if.sv | 39 +++
 rtl/sipo_deser.sv | 87 ++++++++
 tb/tb_sipo_deser.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deser_if.sv
// sipo_deser_if
//   Bundles the serial-side strobes and the word-side handshake of the
//   deserializer so they travel together between producer, block and consumer.
//
//   Signals:
//     sin, sen   serial bit and its sample strobe (MSB of the word first)
//     clr        synchronous abort/clear
//     q_ack      consumer accepts the presented word
//     q, q_valid completed word and its held valid flag
//     busy, cnt  partial-word status and received-bit count
//     overrun    sticky dropped-word flag
//
//   Modports:
//     master  the deserializer itself (drives word side and status)
//     slave   the surrounding logic (drives serial side, clr and q_ack)
interface sipo_deser_if #(
  parameter int SIZE = 4,
  parameter int CNTW = 4
);
  logic            sin;
  logic            sen;
  logic            clr;
  logic            q_ack;
  logic [SIZE-1:0] q;
  logic            q_valid;
  logic            busy;
  logic [CNTW-1:0] cnt;
  logic            overrun;

  modport master (
    input  sin, sen, clr, q_ack,
    output q, q_valid, busy, cnt, overrun
  );

  modport slave (
    output sin, sen, clr, q_ack,
    input  q, q_valid, busy, cnt, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser
//   Serial-in/parallel-out receiver matching a left-shifting serializer.
//   Each strobed bit is appended at the LSB; after SIZE strobes the word is
//   presented on q with a held q_valid until acknowledged. A word that
//   completes while the previous one is still unacknowledged is dropped and
//   the sticky overrun flag is raised.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    sipo_deser_if.master: sin, sen, clr, q_ack in;
//            q, q_valid, busy, cnt, overrun out
module sipo_deser #(
  parameter int SIZE = 4,
  parameter int CNTW = 4
) (
  input  logic           clk,
  input  logic           reset,
  sipo_deser_if.master   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [SIZE-1:0] sh;
  logic [SIZE-1:0] q_r;
  logic            q_valid_r;
  logic [CNTW-1:0] cnt_r;
  logic            overrun_r;

  logic [SIZE-1:0] word;
  logic            last_bit;

  // The word being completed includes the bit sampled on this very edge.
  assign word     = {sh[SIZE-2:0], bus.sin};
  assign last_bit = (cnt_r == CNTW'(SIZE - 1));

  // Single state process: state is IDLE exactly when cnt is zero, so busy
  // is simply the registered state. clr outranks every strobe and ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      cnt_r     <= '0;
      overrun_r <= 1'b0;
    end else if (bus.clr) begin
      state     <= IDLE;
      sh        <= '0;
      q_valid_r <= 1'b0;
      cnt_r     <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (bus.q_ack && q_valid_r)
        q_valid_r <= 1'b0;
      if (bus.sen) begin
        sh <= word;
        if (last_bit) begin
          state <= IDLE;
          cnt_r <= '0;
          // Accept when the slot is free or being freed on this same edge;
          // otherwise the old word is kept and the new one is lost.
          if (!q_valid_r || bus.q_ack) begin
            q_r       <= word;
            q_valid_r <= 1'b1;
          end else begin
            overrun_r <= 1'b1;
          end
        end else begin
          state <= SHIFT;
          cnt_r <= cnt_r + CNTW'(1);
        end
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.busy    = (state == SHIFT);
  assign bus.cnt     = cnt_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser
//   Self-checking bench for sipo_deser with SIZE=4. Words expected to reach
//   q are pushed on a queue when their bits are driven and popped when the
//   completion edge has passed.
module tb_sipo_deser;

  localparam int SIZE = 4;
  localparam int CNTW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  logic [SIZE-1:0] exp_q[$];
  logic [SIZE-1:0] exp_word;

  sipo_deser_if #(.SIZE(SIZE), .CNTW(CNTW)) bus ();

  sipo_deser #(.SIZE(SIZE), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the given strobe/bit/ack; outputs settle by return.
  task automatic drive_bit(input logic en, input logic b, input logic ack);
    bus.sen   = en;
    bus.sin   = b;
    bus.q_ack = ack;
    @(posedge clk);
    #1;
    bus.sen   = 1'b0;
    bus.sin   = 1'b0;
    bus.q_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack_cycle();
    drive_bit(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.sin   = 1'b0;
    bus.sen   = 1'b0;
    bus.clr   = 1'b0;
    bus.q_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.q, bus.q_valid, bus.busy, bus.cnt, bus.overrun} !== '0) begin
      fails++;
      $display("FAIL reset_state: q=%b qv=%b busy=%b cnt=%0d ov=%b, expected all 0",
               bus.q, bus.q_valid, bus.busy, bus.cnt, bus.overrun);
    end
    reset = 1'b0;
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.cnt !== 4'd2) begin
      fails++;
      $display("FAIL reset_precnt: cnt=%0d expected 2", bus.cnt);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.cnt !== 4'd0 || bus.busy !== 1'b0 || bus.q !== 4'd0 || bus.q_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_midword: cnt=%0d busy=%b q=%b qv=%b expected 0/0/0000/0",
               bus.cnt, bus.busy, bus.q, bus.q_valid);
    end
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(4'b0101);
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    exp_word = exp_q.pop_front();
    checks++;
    if (bus.q !== exp_word || bus.q_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_after_word: q=%b qv=%b expected %b/1", bus.q, bus.q_valid, exp_word);
    end
    ack_cycle();
  endtask

  task automatic test_basic_frame();
    logic [3:0] bits;
    logic [CNTW-1:0] exp_cnt[4];
    bits = 4'b1011;
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd0};
    exp_q.push_back(bits);
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, bits[3-i], 1'b0);
      checks++;
      if (bus.cnt !== exp_cnt[i]) begin
        fails++;
        $display("FAIL basic_cnt%0d: cnt=%0d expected %0d", i, bus.cnt, exp_cnt[i]);
      end
      if (i == 0) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL basic_busy: busy=%b expected 1", bus.busy);
        end
      end
    end
    exp_word = exp_q.pop_front();
    checks++;
    if (bus.q !== exp_word || bus.q_valid !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_word: q=%b qv=%b busy=%b expected %b/1/0",
               bus.q, bus.q_valid, bus.busy, exp_word);
    end
    ack_cycle();
    checks++;
    if (bus.q_valid !== 1'b0 || bus.q !== exp_word) begin
      fails++;
      $display("FAIL basic_ack: qv=%b q=%b expected 0/%b", bus.q_valid, bus.q, exp_word);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] bits;
    bits = 4'b1100;
    exp_q.push_back(bits);
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, bits[3-i], 1'b0);
      if (i < 3) begin
        idle_cycles(3);
        checks++;
        if (bus.cnt !== CNTW'(i + 1) || bus.q_valid !== 1'b0) begin
          fails++;
          $display("FAIL gap_hold%0d: cnt=%0d qv=%b expected %0d/0", i, bus.cnt, bus.q_valid, i + 1);
        end
      end
    end
    exp_word = exp_q.pop_front();
    checks++;
    if (bus.q !== exp_word || bus.q_valid !== 1'b1) begin
      fails++;
      $display("FAIL gap_word: q=%b qv=%b expected %b/1", bus.q, bus.q_valid, exp_word);
    end
    ack_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bits = 8'b1001_0110;
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0110);
    for (int i = 0; i < 8; i++) begin
      drive_bit(1'b1, bits[7-i], (i == 7) ? 1'b1 : 1'b0);
      if (i == 3) begin
        exp_word = exp_q.pop_front();
        checks++;
        if (bus.q !== exp_word || bus.q_valid !== 1'b1) begin
          fails++;
          $display("FAIL b2b_word1: q=%b qv=%b expected %b/1", bus.q, bus.q_valid, exp_word);
        end
      end
    end
    exp_word = exp_q.pop_front();
    checks++;
    if (bus.q !== exp_word || bus.q_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL b2b_word2: q=%b qv=%b ov=%b expected %b/1/0",
               bus.q, bus.q_valid, bus.overrun, exp_word);
    end
    ack_cycle();
  endtask

  task automatic test_overrun();
    logic [11:0] bits;
    bits = 12'b1111_0001_0011;
    exp_q.push_back(4'b1111);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, bits[11-i], 1'b0);
    exp_word = exp_q.pop_front();
    checks++;
    if (bus.q !== exp_word || bus.q_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_first: q=%b qv=%b expected %b/1", bus.q, bus.q_valid, exp_word);
    end
    for (int i = 4; i < 8; i++) drive_bit(1'b1, bits[11-i], 1'b0);
    checks++;
    if (bus.q !== 4'b1111 || bus.overrun !== 1'b1 || bus.cnt !== 4'd0 || bus.q_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_drop: q=%b ov=%b cnt=%0d qv=%b expected 1111/1/0/1",
               bus.q, bus.overrun, bus.cnt, bus.q_valid);
    end
    ack_cycle();
    exp_q.push_back(4'b0011);
    for (int i = 8; i < 12; i++) drive_bit(1'b1, bits[11-i], 1'b0);
    exp_word = exp_q.pop_front();
    checks++;
    if (bus.q !== exp_word || bus.overrun !== 1'b1 || bus.q_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovr_sticky: q=%b ov=%b qv=%b expected %b/1/1",
               bus.q, bus.overrun, bus.q_valid, exp_word);
    end
  endtask

  task automatic test_clear();
    logic [3:0] bits;
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    bus.clr = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b1);
    bus.clr = 1'b0;
    checks++;
    if (bus.cnt !== 4'd0 || bus.busy !== 1'b0 || bus.q_valid !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.q !== 4'b0011) begin
      fails++;
      $display("FAIL clear: cnt=%0d busy=%b qv=%b ov=%b q=%b expected 0/0/0/0/0011",
               bus.cnt, bus.busy, bus.q_valid, bus.overrun, bus.q);
    end
    bits = 4'b1000;
    exp_q.push_back(bits);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, bits[3-i], 1'b0);
    exp_word = exp_q.pop_front();
    checks++;
    if (bus.q !== exp_word || bus.q_valid !== 1'b1) begin
      fails++;
      $display("FAIL clear_next: q=%b qv=%b expected %b/1", bus.q, bus.q_valid, exp_word);
    end
    ack_cycle();
  endtask

  task automatic test_stream();
    logic [3:0] w;
    for (int k = 0; k < 6; k++) begin
      w = 4'($urandom_range(0, 15));
      exp_q.push_back(w);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, w[3-i], (i == 3) ? 1'b1 : 1'b0);
      exp_word = exp_q.pop_front();
      checks++;
      if (bus.q !== exp_word || bus.q_valid !== 1'b1 || bus.overrun !== 1'b0) begin
        fails++;
        $display("FAIL stream%0d: q=%b qv=%b ov=%b expected %b/1/0",
                 k, bus.q, bus.q_valid, bus.overrun, exp_word);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic_frame();
    test_gapped();
    test_back_to_back();
    test_overrun();
    test_clear();
    test_stream();
    $display("[TB] scoreboard entries left: %0d", exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
